// File: rtl/oled_pkg.sv
// Shared definitions for the OLED message sequencer: state encoding and
// display geometry constants.
package oled_pkg;

  localparam int unsigned ROWS          = 4;
  localparam int unsigned CHARS_DEFAULT = 12;
  localparam logic [7:0]  ASCII_SPACE   = 8'h20;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StNext,
    StFdone
  } state_e;

endpackage

// File: rtl/oled_wdog.sv
// Character-done watchdog: counts enabled cycles and pulses expire on the
// TIMEOUT-th one; clr restarts the count.
module oled_wdog #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt;

  assign expire = en && (cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/oled_msg_sequencer.sv
// Streams four snapshotted message lines to the OLED character writer, one
// character per strobe, paced by char_done with a watchdog fallback.
module oled_msg_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned CHARS   = CHARS_DEFAULT,
  parameter int unsigned WIDTH   = CHARS * 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     refresh_req,
  input  logic                     disp_en,
  input  logic [WIDTH-1:0]         soda_price,
  input  logic [WIDTH-1:0]         coin_val,
  input  logic [WIDTH-1:0]         coins_tot,
  input  logic [WIDTH-1:0]         disp,
  input  logic                     char_done,
  output logic [7:0]               char_data,
  output logic [1:0]               char_row,
  output logic [$clog2(CHARS)-1:0] char_col,
  output logic                     char_wr,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout_err
);

  localparam int unsigned ColW = $clog2(CHARS);

  state_e                  state;
  logic                    pending;
  logic [ROWS*WIDTH-1:0]   snap;
  logic [WIDTH-1:0]        line3;
  logic                    last_col;
  logic                    last_row;
  logic [1:0]              row_nx;
  logic [ColW-1:0]         col_nx;
  logic                    wd_en;
  logic                    wd_expire;

  // Line 0 occupies the top of the snapshot; char 0 is the top byte of a line.
  function automatic logic [7:0] sel_byte(input logic [ROWS*WIDTH-1:0] s,
                                          input logic [1:0] r,
                                          input logic [ColW-1:0] c);
    return 8'(s >> ((ROWS * WIDTH - 8) - (32'(r) * WIDTH + 32'(c) * 8)));
  endfunction

  assign line3 = disp_en ? disp : {CHARS{ASCII_SPACE}};
  assign wd_en = (state == StWait);

  always_comb begin
    last_col = (char_col == ColW'(CHARS - 1));
    last_row = (char_row == 2'(ROWS - 1));
    row_nx   = char_row;
    col_nx   = char_col + ColW'(1);
    if (last_col) begin
      col_nx = '0;
      row_nx = char_row + 2'd1;
    end
  end

  oled_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wd_en),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      pending     <= 1'b0;
      snap        <= '0;
      char_data   <= '0;
      char_row    <= '0;
      char_col    <= '0;
      char_wr     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Requests during a frame collapse into one redraw after it.
      if (state != StIdle && refresh_req) pending <= 1'b1;
      unique case (state)
        StIdle: begin
          if (refresh_req || pending) begin
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= StLoad;
          end
        end
        StLoad: begin
          snap      <= {soda_price, coin_val, coins_tot, line3};
          char_data <= soda_price[WIDTH-1 -: 8];
          char_row  <= '0;
          char_col  <= '0;
          char_wr   <= 1'b1;
          state     <= StSend;
        end
        StSend: begin
          char_wr <= 1'b0;
          state   <= StWait;
        end
        StWait: begin
          if (char_done) begin
            state <= StNext;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            state       <= StNext;
          end
        end
        StNext: begin
          if (last_row && last_col) begin
            frame_done <= 1'b1;
            state      <= StFdone;
          end else begin
            char_row  <= row_nx;
            char_col  <= col_nx;
            char_data <= sel_byte(snap, row_nx, col_nx);
            char_wr   <= 1'b1;
            state     <= StSend;
          end
        end
        StFdone: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
